// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ro_in over
// back-to-back windows of GATE_CYCLES clocks and offers each count on a valid/ready port.
// Define RO_FREQ_SAT_EN to make the edge counter saturate instead of wrapping.
module ro_freq_counter #(
  parameter int GATE_CYCLES = 100000,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ro_in,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic [GW-1:0]        r_gate_cnt;
  logic [CNT_WIDTH-1:0] r_edge_cnt;
  logic [CNT_WIDTH-1:0] r_m_data;
  logic                 r_m_valid;
  logic                 r_overrun;

  logic                 w_edge;
  logic                 w_active;
  logic                 w_win_end;
  logic                 w_xfer;
  logic [CNT_WIDTH-1:0] w_edge_sum;

  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_active  = (r_state == MEASURE) && en;
  assign w_win_end = w_active && (r_gate_cnt == GATE_LAST);
  assign w_xfer    = r_m_valid & m_ready;

  // Count including this cycle's edge, so the window-end cycle is never lost.
  always_comb begin
`ifdef RO_FREQ_SAT_EN
    w_edge_sum = (w_edge && (r_edge_cnt != '1)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
`else
    w_edge_sum = r_edge_cnt + CNT_WIDTH'(w_edge);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ro_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en)  w_state_nxt = MEASURE;
      MEASURE: if (!en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counters only run while measuring; leaving MEASURE discards the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
    end else if (!w_active || w_win_end) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
      r_edge_cnt <= w_edge_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_win_end) begin
      r_m_data  <= w_edge_sum;
      r_m_valid <= 1'b1;
    end else if (w_xfer) begin
      r_m_valid <= 1'b0;
    end
  end

  // Setting wins over clearing when an unaccepted result is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_overrun <= 1'b0;
    else if (w_win_end && r_m_valid && !m_ready) r_overrun <= 1'b1;
    else if (w_xfer)                             r_overrun <= 1'b0;
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign overrun = r_overrun;

endmodule
